// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : CPU-side bus of the iterative multiply/divide unit. The
//                master modport is the pipeline, the slave modport the unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int DataWidth = 32
);
    logic                 enable;
    logic                 start;
    logic [2:0]           op;
    logic [DataWidth-1:0] a;
    logic [DataWidth-1:0] b;
    logic                 mthi;
    logic                 mtlo;
    logic                 flush;
    logic                 busy;
    logic                 done;
    logic [DataWidth-1:0] high;
    logic [DataWidth-1:0] low;

    modport master (
        output enable, start, op, a, b, mthi, mtlo, flush,
        input  busy, done, high, low
    );

    modport slave (
        input  enable, start, op, a, b, mthi, mtlo, flush,
        output busy, done, high, low
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative multiply / divide / multiply-accumulate unit that
//                owns the HI/LO registers. One result bit per cycle, fixed
//                latency of DataWidth+1 cycles, busy/done handshake, flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int DataWidth = 32
) (
    input  wire logic clock,
    input  wire logic reset,
    muldiv_if.slave   bus
);

    localparam int CNT_W  = $clog2(DataWidth + 1);
    localparam int PROD_W = 2 * DataWidth;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic                 is_div_q, is_div_d;   // divide (vs multiply family)
    logic                 is_sub_q, is_sub_d;   // MSUB/MSUBU
    logic                 neg_lo_q, neg_lo_d;   // negate product / quotient
    logic                 neg_hi_q, neg_hi_d;   // negate remainder
    logic                 div0_q,   div0_d;     // divisor was zero
    logic [DataWidth-1:0] mag_q,    mag_d;      // |b|: multiplicand or divisor
    logic [PROD_W-1:0]    work_q,   work_d;     // {partial, multiplier} or {rem, quo}
    logic [PROD_W-1:0]    acc_q,    acc_d;      // accumulator, or {a, 0} for divides
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [DataWidth-1:0] hi_q,     hi_d;
    logic [DataWidth-1:0] lo_q,     lo_d;
    logic                 done_q,   done_d;

    // ------------------------------------------------------------------
    // Operand decode for the accepting edge
    // ------------------------------------------------------------------
    logic                 op_div;
    logic                 op_acc;
    logic                 op_signed;
    logic                 sign_a;
    logic                 sign_b;
    logic [DataWidth-1:0] abs_a;
    logic [DataWidth-1:0] abs_b;

    assign op_div    = (bus.op[2:1] == 2'b01);
    assign op_acc    = bus.op[2];
    assign op_signed = ~bus.op[0];
    assign sign_a    = op_signed & bus.a[DataWidth-1];
    assign sign_b    = op_signed & bus.b[DataWidth-1];
    assign abs_a     = sign_a ? (~bus.a + 1'b1) : bus.a;
    assign abs_b     = sign_b ? (~bus.b + 1'b1) : bus.b;

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit (LSB) is set, then shift the whole pair right.
    logic [DataWidth:0]   mul_sum;
    // Restoring division: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits; the quotient bit enters at the LSB.
    logic [DataWidth:0]   div_shift;
    logic [DataWidth:0]   div_diff;
    logic                 div_ge;

    assign mul_sum   = {1'b0, work_q[PROD_W-1:DataWidth]}
                     + (work_q[0] ? {1'b0, mag_q} : {(DataWidth + 1){1'b0}});
    assign div_shift = {work_q[PROD_W-1:DataWidth], work_q[DataWidth-1]};
    assign div_diff  = div_shift - {1'b0, mag_q};
    assign div_ge    = (div_shift >= {1'b0, mag_q});

    // ------------------------------------------------------------------
    // Final sign correction and accumulation
    // ------------------------------------------------------------------
    logic [PROD_W-1:0]    prod_signed;
    logic [PROD_W-1:0]    mul_result;
    logic [DataWidth-1:0] quo_signed;
    logic [DataWidth-1:0] rem_signed;

    assign prod_signed = neg_lo_q ? (~work_q + 1'b1) : work_q;
    assign mul_result  = is_sub_q ? (acc_q - prod_signed) : (acc_q + prod_signed);
    assign quo_signed  = neg_lo_q ? (~work_q[DataWidth-1:0] + 1'b1)
                                  : work_q[DataWidth-1:0];
    assign rem_signed  = neg_hi_q ? (~work_q[PROD_W-1:DataWidth] + 1'b1)
                                  : work_q[PROD_W-1:DataWidth];

    // Next-state and datapath update; everything holds while enable is low
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        is_sub_d = is_sub_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        mag_d    = mag_q;
        work_d   = work_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = done_q;

        if (bus.enable) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // start wins over mthi/mtlo; accumulator sees pre-edge HI/LO
                        state_d  = RUN;
                        is_div_d = op_div;
                        is_sub_d = op_acc & bus.op[1];
                        neg_lo_d = sign_a ^ sign_b;
                        neg_hi_d = sign_a;
                        div0_d   = (bus.b == {DataWidth{1'b0}});
                        mag_d    = abs_b;
                        work_d   = {{DataWidth{1'b0}}, abs_a};
                        if (op_acc) begin
                            acc_d = {hi_q, lo_q};
                        end else if (op_div) begin
                            acc_d = {bus.a, {DataWidth{1'b0}}};
                        end else begin
                            acc_d = {PROD_W{1'b0}};
                        end
                        cnt_d    = CNT_W'(DataWidth);
                    end else begin
                        if (bus.mthi) hi_d = bus.a;
                        if (bus.mtlo) lo_d = bus.a;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state_d = IDLE;
                    end else begin
                        if (is_div_q) begin
                            work_d = {div_ge ? div_diff[DataWidth-1:0] : div_shift[DataWidth-1:0],
                                      work_q[DataWidth-2:0], div_ge};
                        end else begin
                            work_d = {mul_sum, work_q[DataWidth-1:1]};
                        end
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = FINISH;
                        end
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                    if (!bus.flush) begin
                        done_d = 1'b1;
                        if (!is_div_q) begin
                            hi_d = mul_result[PROD_W-1:DataWidth];
                            lo_d = mul_result[DataWidth-1:0];
                        end else if (div0_q) begin
                            hi_d = acc_q[PROD_W-1:DataWidth];
                            lo_d = {DataWidth{1'b1}};
                        end else begin
                            hi_d = rem_signed;
                            lo_d = quo_signed;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            is_sub_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            mag_q    <= {DataWidth{1'b0}};
            work_q   <= {PROD_W{1'b0}};
            acc_q    <= {PROD_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            hi_q     <= {DataWidth{1'b0}};
            lo_q     <= {DataWidth{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            is_sub_q <= is_sub_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            mag_q    <= mag_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.high = hi_q;
    assign bus.low  = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed and random checks of muldiv_unit (DataWidth=32)
//                with a result scoreboard and a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    muldiv_if #(.DataWidth(32)) bus ();

    muldiv_unit #(.DataWidth(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] sb[$];
    logic [63:0] m_acc;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural reference for {HI,LO}
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sa, sbv, q, r;
        sp  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        up  = {32'd0, a} * {32'd0, b};
        sa  = a;
        sbv = b;
        case (op)
            3'd0: return sp;
            3'd1: return up;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sbv;
                r = sa % sbv;
                return {r, q};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return acc + sp;
            3'd5: return acc + up;
            3'd6: return acc - sp;
            default: return acc - up;
        endcase
    endfunction

    // inj: 0 none, 1 start while busy, 2 mtlo while busy, 3 freeze 3 cycles,
    //      4 mthi with start, 5 freeze during done, 6 leave in done cycle
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int inj);
        int          lat;
        int          busy_n;
        int          exp_lat;
        logic [63:0] pre;
        logic [63:0] want;
        exp_lat   = (inj == 3) ? 36 : 33;
        pre       = {bus.high, bus.low};
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (inj == 4) bus.mthi = 1'b1;
        step();
        sb.push_back(exp);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.a     = 32'hA5A5_5A5A;
        bus.b     = 32'h0000_0003;
        if (inj == 4) check({tag, "_mthi_dropped"}, 64'(bus.high), 64'(pre[63:32]));
        lat    = 0;
        busy_n = 0;
        while (!bus.done && lat < 200) begin
            if (bus.busy) busy_n++;
            if (lat == 5) begin
                if (inj == 1) begin
                    bus.start = 1'b1;
                    bus.op    = 3'd1;
                end
                if (inj == 2) bus.mtlo = 1'b1;
                if (inj == 3) bus.enable = 1'b0;
            end
            if (lat == 6) begin
                bus.start = 1'b0;
                bus.mtlo  = 1'b0;
                if (inj == 2) check({tag, "_mtlo_ignored"}, 64'(bus.low), 64'(pre[31:0]));
            end
            if (lat == 8 && inj == 3) bus.enable = 1'b1;
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
        want  = sb.pop_front();
        check({tag, "_result"}, {bus.high, bus.low}, want);
        m_acc = want;
        if (inj == 5) begin
            bus.enable = 1'b0;
            step();
            step();
            check({tag, "_done_held"}, 64'(bus.done), 64'd1);
            bus.enable = 1'b1;
        end
        if (inj != 6) begin
            step();
            check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        end
    endtask

    task automatic write_hilo(input string tag, input logic hi_en, input logic lo_en,
                              input logic [31:0] val);
        bus.mthi = hi_en;
        bus.mtlo = lo_en;
        bus.a    = val;
        step();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (hi_en) m_acc[63:32] = val;
        if (lo_en) m_acc[31:0]  = val;
        check(tag, {bus.high, bus.low}, m_acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          seen;

        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        bus.flush  = 1'b0;
        m_acc      = 64'd0;
        repeat (3) step();
        check("reset_flags", {62'd0, bus.busy, bus.done}, 64'd0);
        check("reset_hilo", {bus.high, bus.low}, 64'd0);
        reset = 1'b0;
        step();

        // Full-range multiplies
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
        run_op("mult_neg", 3'd0, -32'sd3, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0);

        // Accumulate
        write_hilo("mthi_mtlo_both", 1'b1, 1'b1, 32'h0000_0077);
        write_hilo("mthi_zero", 1'b1, 1'b0, 32'd0);
        write_hilo("mtlo_ten", 1'b0, 1'b1, 32'd10);
        run_op("madd", 3'd4, -32'sd2, 32'd3, 64'h0000_0000_0000_0004, 0);
        run_op("msubu", 3'd7, 32'd5, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("start_mthi", 3'd5, 32'd2, 32'd3, 64'h0000_0000_0000_0005, 4);

        // Divide
        run_op("div_neg", 3'd2, -32'sd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
        run_op("divu_zero", 3'd3, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 0);
        run_op("div_zero", 3'd2, -32'sd5, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 0);

        // Protocol while busy, freeze and back-to-back
        run_op("start_busy", 3'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1);
        run_op("mtlo_busy", 3'd1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 2);
        run_op("freeze", 3'd6, 32'd3, -32'sd4, 64'h0000_0001_0000_000C, 3);
        run_op("done_hold", 3'd1, 32'd7, 32'd8, 64'd56, 5);
        run_op("b2b_first", 3'd1, 32'd3, 32'd3, 64'd9, 6);
        run_op("b2b_second", 3'd0, 32'd4, -32'sd4, 64'hFFFF_FFFF_FFFF_FFF0, 0);

        // Random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i == 3) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb, m_acc), 0);
        end

        // Flush in RUN cycle 10 together with an ignored start
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        check("flush_busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd0;
        step();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush_busy_drop", 64'(bus.busy), 64'd0);
        seen = 0;
        repeat (40) begin
            if (bus.done || bus.busy) seen++;
            step();
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_hilo_kept", {bus.high, bus.low}, m_acc);

        // Asynchronous reset during RUN cycle 5
        write_hilo("pre_reset_lo", 1'b0, 1'b1, 32'h0000_0055);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.a     = 32'd11;
        bus.b     = 32'd13;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        check("rst_busy_before", 64'(bus.busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_flags", {62'd0, bus.busy, bus.done}, 64'd0);
        check("rst_async_hilo", {bus.high, bus.low}, 64'd0);
        step();
        reset = 1'b0;
        m_acc = 64'd0;
        repeat (3) step();
        check("rst_after_flags", {62'd0, bus.busy, bus.done}, 64'd0);
        check("rst_after_hilo", {bus.high, bus.low}, m_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit owning the HI/LO architectural registers. It replaces single-cycle combinational multiply/divide plus separate HI/LO registers in the CPU datapath. It adds signed/unsigned multiply-accumulate (MADD/MSUB), a busy/done handshake for pipeline stalling, a flush, and a width parameter. Each operation takes a fixed DataWidth+1 cycles.

## Interface
- DataWidth, 32: operand and HI/LO width; even, ≥4.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  0 freezes all state; start, flush, mthi and mtlo are ignored.
- start  in  1  request operation; accepted only in IDLE.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- a  in  DataWidth  multiplicand/dividend, sampled at the accepting edge.
- b  in  DataWidth  multiplier/divisor, sampled at the accepting edge.
- mthi  in  1  write a into HI (IDLE only).
- mtlo  in  1  write a into LO (IDLE only).
- flush  in  1  abort the operation in flight.
- busy  out  1  operation in progress; the CPU stalls MFHI/MFLO/new ops on it.
- done  out  1  one-cycle pulse: HI/LO were just updated by a finished operation.
- high  out  DataWidth  HI register.
- low  out  DataWidth  LO register.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE → RUN on start. The accepting edge latches:
  - op
  - |a| and |b| (magnitudes for signed ops)
  - result signs
  - {HI,LO} as the accumulator for MADD/MSUB
  - the iteration counter, set to DataWidth
- RUN, one bit per edge:
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - The counter decrements each edge; at 1 the FSM moves to FINISH.
- FINISH (one edge): apply sign correction and accumulation, write HI/LO, then → IDLE with done=1 for the following cycle.
- Multiply results:
  - MULT/MULTU: {HI,LO} = a·b, full 2·DataWidth product.
  - MADD(U): {HI,LO} = acc + a·b, modulo 2^(2·DataWidth).
  - MSUB(U): {HI,LO} = acc − a·b, modulo 2^(2·DataWidth).
  - Signed variants use two's-complement operands and product.
- Divide results:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
- Divide by zero (any signedness): LO = all ones, HI = a. Same latency.
- Signed overflow, −2^(DataWidth−1) / −1: LO = −2^(DataWidth−1), HI = 0.
- mthi/mtlo in IDLE with start=0: write at the edge. Both may be asserted together.
- start together with mthi/mtlo: start wins and the writes are dropped. The accumulator sees the pre-edge HI/LO.
- While busy: start, mthi and mtlo are ignored.
- flush in RUN or FINISH: → IDLE at that edge. HI/LO unchanged, no done.
- flush in IDLE: no effect.
- flush has priority over FINISH completion.

## Timing
- Reset values: state IDLE, busy=0, done=0, high=0, low=0, counter=0.
- Reset asserted mid-operation aborts immediately. Same values, no done.
- busy is combinational from state: 1 in RUN and FINISH.
  - High for exactly DataWidth+1 cycles after the accepting edge.
- Latency: start accepted at edge E0 → HI/LO updated at edge E0+DataWidth+1. done is high during the cycle after that edge.
- Back-to-back: a new start may be accepted during the done cycle, giving a throughput of one op per DataWidth+2 cycles.
- done is registered and lasts exactly one cycle.
- enable=0 stretches all latencies cycle-for-cycle. done is held while frozen.

## Test plan
- Reset. Then with DataWidth=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. done exactly 34 cycles after start; busy high for 33 cycles.
- MULT a=−3 b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Accumulate: mthi 0, mtlo 10. Then MADD a=−2 b=3 → LO=4, HI=0. Then MSUBU a=5 b=1 → {HI,LO}=0xFFFFFFFF_FFFFFFFF.
- Divide:
  - DIV a=−7 b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV a=0x80000000 b=−1 → LO=0x80000000, HI=0.
  - DIVU a=9 b=0 → LO=0xFFFFFFFF, HI=9.
- Flush on the 10th RUN cycle → busy drops next cycle, no done, HI/LO keep their prior values. A start pulsed in the same cycle as the flush is ignored.
- Protocol:
  - start while busy → ignored.
  - mtlo while busy → ignored.
  - start+mthi in IDLE → operation runs, HI is not written by mthi.
  - Async reset at RUN cycle 5 → all outputs 0 immediately.
